// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the core-side RAM arbitration path.
package riscv_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // IDLE arbitrates; RMW_WR finishes the write half of a partial store.
    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Per byte lane: take the new byte where be is set, otherwise keep the old one.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_arb_prio.sv
// Winner select between instruction and data requests, with an anti-starvation
// counter that lets a waiting instruction fetch through after STARVE_LIMIT losses.
module ram_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic i_win,
    output logic d_win
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_reg;

    // Data has priority unless the instruction side has been starved long enough.
    always_comb begin
        i_win = arb_en && i_req && (!d_req || (starve_cnt_reg == LIMIT));
        d_win = arb_en && d_req && !i_win;
    end

    // Count consecutive lost arbitration cycles; frozen while not arbitrating.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            starve_cnt_reg <= 4'd0;
        end else if (arb_en) begin
            if (!i_req || i_win) begin
                starve_cnt_reg <= 4'd0;
            end else if (starve_cnt_reg != LIMIT) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between instruction fetch and load/store.
// Partial stores become a read-modify-write because the RAM has no byte enables.
module ram_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [AW-1:0]     d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic [AW-1:0]     ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [WORD_W-1:0] ram_rdata
);

    state_t            state_reg;
    state_t            state_next;
    logic [AW-1:0]     rmw_addr_reg;
    logic [WORD_W-1:0] rmw_wdata_reg;
    logic [3:0]        rmw_be_reg;
    logic              i_own_reg;
    logic              d_own_reg;
    logic              d_done_reg;
    logic              arb_en;
    logic              d_partial;

    // Grants are only possible in IDLE and never while reset is asserted.
    assign arb_en    = (state_reg == IDLE) && !p_reset;
    assign d_partial = d_we && (d_be != BE_FULL) && (d_be != BE_NONE);

    ram_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .m_clock(m_clock),
        .p_reset(p_reset),
        .arb_en (arb_en),
        .i_req  (i_req),
        .d_req  (d_req),
        .i_win  (i_gnt),
        .d_win  (d_gnt)
    );

    // Read data is passed straight through; the owner bits decide who sees it.
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;
    assign i_rvalid = i_own_reg;
    assign d_rvalid = d_own_reg;
    assign d_done   = d_done_reg;

    // RAM strobes and next state from the granted request or the pending RMW.
    always_comb begin
        state_next = state_reg;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_rden   = 1'b0;
        ram_wren   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_gnt) begin
                    ram_addr = i_addr;
                    ram_rden = 1'b1;
                end else if (d_gnt) begin
                    ram_addr  = d_addr;
                    ram_wdata = d_wdata;
                    if (!d_we) begin
                        ram_rden = 1'b1;
                    end else if (d_be == BE_FULL) begin
                        ram_wren = 1'b1;
                    end else if (d_be != BE_NONE) begin
                        ram_rden   = 1'b1;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                ram_addr   = rmw_addr_reg;
                ram_wdata  = merge_bytes(ram_rdata, rmw_wdata_reg, rmw_be_reg);
                ram_wren   = !p_reset;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, read-owner flags and store completion.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_reg  <= IDLE;
            i_own_reg  <= 1'b0;
            d_own_reg  <= 1'b0;
            d_done_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            i_own_reg  <= i_gnt;
            d_own_reg  <= d_gnt && !d_we;
            d_done_reg <= (d_gnt && d_we && !d_partial) || (state_reg == RMW_WR);
        end
    end

    // Capture the partial-store fields for the write half of the RMW.
    always_ff @(posedge m_clock) begin
        if (d_gnt && d_partial) begin
            rmw_addr_reg  <= d_addr;
            rmw_wdata_reg <= d_wdata;
            rmw_be_reg    <= d_be;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rden;
    logic        ram_wren;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    ram_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rden (ram_rden),
        .ram_wren (ram_wren),
        .ram_rdata(ram_rdata)
    );

    always #5 m_clock = ~m_clock;

    // Single-port RAM: word index addr[13:2], registered read one cycle later.
    always @(posedge m_clock) begin
        if (ram_wren) mem[ram_addr[13:2]] <= ram_wdata;
        if (ram_rden) ram_rdata <= mem[ram_addr[13:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge m_clock);
        #1;
    endtask

    initial begin
        for (int w = 0; w < 4096; w++) mem[w] = 32'h0;
        mem[0]     = 32'h11;
        mem[1]     = 32'h22;
        mem[2]     = 32'h33;
        mem[12'h40] = 32'hAABBCCDD;
        mem[12'h80] = 32'h5A5A5A5A;
        mem[12'h81] = 32'h0;
        mem[12'hC0] = 32'h12345678;
        ram_rdata = 32'h0;

        p_reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset held two cycles with both requests high.
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_rden", ram_rden, 0);
            check("rst_wren", ram_wren, 0);
            $display("txn reset cycle %0d", c);
        end
        p_reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        #1;
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_d_done", d_done, 0);
        next_cycle();

        // Instruction stream: three consecutive fetches.
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = 32'(4 * k);
            #1;
            check("ifetch_gnt", i_gnt, 1);
            check("ifetch_rden", ram_rden, 1);
            check("ifetch_addr", ram_addr, 32'(4 * k));
            if (k > 0) begin
                check("ifetch_rvalid", i_rvalid, 1);
                check("ifetch_rdata", i_rdata, 32'(17 * k));
            end
            $display("txn ifetch addr=0x%08h", i_addr);
            next_cycle();
        end
        i_req = 1'b0;
        #1;
        check("ifetch_rvalid_last", i_rvalid, 1);
        check("ifetch_rdata_last", i_rdata, 32'h33);
        next_cycle();
        #1;
        check("ifetch_rvalid_off", i_rvalid, 0);

        // Partial store into 0xAABBCCDD with be=0101.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 32'h100; d_wdata = 32'h11223344;
        #1;
        check("rmw_gnt", d_gnt, 1);
        check("rmw_rden", ram_rden, 1);
        check("rmw_no_wren_n", ram_wren, 0);
        check("rmw_rd_addr", ram_addr, 32'h100);
        next_cycle();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
        #1;
        check("rmw_no_i_gnt", i_gnt, 0);
        check("rmw_wren", ram_wren, 1);
        check("rmw_wdata", ram_wdata, 32'hAA22CC44);
        check("rmw_wr_addr", ram_addr, 32'h100);
        check("rmw_done_early", d_done, 0);
        next_cycle();
        #1;
        check("rmw_done", d_done, 1);
        check("rmw_i_gnt_after", i_gnt, 1);
        $display("txn partial store addr=0x100 be=0101");
        next_cycle();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        check("post_rmw_i_rdata", i_rdata, 32'h11);
        check("post_rmw_i_rvalid", i_rvalid, 1);
        check("readback_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0;
        #1;
        check("readback_rvalid", d_rvalid, 1);
        check("readback_rdata", d_rdata, 32'hAA22CC44);
        $display("txn load addr=0x100 data=0x%08h", d_rdata);
        next_cycle();

        // Contention: both held; expect four data grants then one fetch, repeating.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        i_req = 1'b1; i_addr = 32'h4;
        begin
            logic prev_i;
            prev_i = 1'b0;
            for (int k = 0; k < 10; k++) begin
                logic exp_i;
                exp_i = (k % 5 == 4);
                #1;
                check("cont_i_gnt", i_gnt, exp_i);
                check("cont_d_gnt", d_gnt, !exp_i);
                if (k > 0) check("cont_i_rvalid", i_rvalid, prev_i);
                if (prev_i) check("cont_i_rdata", i_rdata, 32'h22);
                $display("txn contention cycle %0d i_gnt=%0b d_gnt=%0b", k, i_gnt, d_gnt);
                prev_i = exp_i;
                next_cycle();
            end
        end
        i_req = 1'b0; d_req = 1'b0;

        // Zero-byte store then full store, then read both words back.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h200; d_wdata = 32'hFFFFFFFF;
        #1;
        check("zero_gnt", d_gnt, 1);
        check("zero_rden", ram_rden, 0);
        check("zero_wren", ram_wren, 0);
        next_cycle();
        d_be = 4'hF; d_addr = 32'h204; d_wdata = 32'hDEADBEEF;
        #1;
        check("zero_done", d_done, 1);
        check("full_gnt", d_gnt, 1);
        check("full_wren", ram_wren, 1);
        check("full_rden", ram_rden, 0);
        check("full_wdata", ram_wdata, 32'hDEADBEEF);
        $display("txn zero store 0x200, full store 0x204");
        next_cycle();
        d_we = 1'b0; d_addr = 32'h200;
        #1;
        check("full_done", d_done, 1);
        check("ld200_gnt", d_gnt, 1);
        next_cycle();
        d_addr = 32'h204;
        #1;
        check("ld200_rvalid", d_rvalid, 1);
        check("ld200_rdata", d_rdata, 32'h5A5A5A5A);
        check("ld_no_done", d_done, 0);
        next_cycle();
        d_req = 1'b0;
        #1;
        check("ld204_rdata", d_rdata, 32'hDEADBEEF);
        $display("txn load 0x204 data=0x%08h", d_rdata);
        next_cycle();

        // Reset in the RMW write cycle aborts the store.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h300; d_wdata = 32'hFFFFFFFF;
        #1;
        check("abort_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0; p_reset = 1'b1;
        #1;
        check("abort_no_wren", ram_wren, 0);
        next_cycle();
        p_reset = 1'b0;
        #1;
        check("abort_no_done", d_done, 0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        check("abort_idle_gnt", d_gnt, 1);
        check("abort_idle_rden", ram_rden, 1);
        next_cycle();
        d_req = 1'b0;
        #1;
        check("abort_rvalid", d_rvalid, 1);
        check("abort_word", d_rdata, 32'h12345678);
        $display("txn reset during RMW, word 0x300=0x%08h", d_rdata);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
